// File: rtl/note_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// note_sequencer_pkg
// Shared definitions for the note sequencer:
//   - note code constants (rest, C4..B4 chromatic, end marker)
//   - frequency*100 table for C4..B4
//   - half-period arithmetic and the code -> half-period lookup table
//   - default melody ROM contents
// Ports: none (package).
// -----------------------------------------------------------------------------
package note_sequencer_pkg;

  localparam int unsigned HP_W = 16;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_E4   = 4'd5;
  localparam logic [3:0] NOTE_G4   = 4'd8;
  localparam logic [3:0] NOTE_B4   = 4'd12;
  localparam logic [3:0] NOTE_END  = 4'd15;

  // Frequencies of C4..B4 in units of 0.01 Hz.
  localparam int unsigned FREQ_X100 [12] = '{
    26163, 27718, 29366, 31113, 32963, 34923,
    36999, 39200, 41530, 44000, 46616, 49388
  };

  typedef struct packed {
    logic [3:0] code;
    logic [7:0] dur;
  } rom_entry_t;

  // One 16-bit half period per 4-bit note code.
  typedef logic [15:0][HP_W-1:0] hp_table_t;

  function automatic logic is_tone(input logic [3:0] code);
    return (code >= NOTE_C4) && (code <= NOTE_B4);
  endfunction

  // Clock cycles per half period, full 32-bit result before truncation.
  function automatic logic [31:0] half_period(input int unsigned clk_hz,
                                              input int unsigned freq_x100);
    return (clk_hz * 32'd100) / (32'd2 * freq_x100);
  endfunction

  function automatic logic [31:0] max_half_period(input int unsigned clk_hz);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 12; i++) begin
      if (half_period(clk_hz, FREQ_X100[i]) > m) m = half_period(clk_hz, FREQ_X100[i]);
    end
    return m;
  endfunction

  // Rests and the end marker map to a half period of 0.
  function automatic hp_table_t build_hp_table(input int unsigned clk_hz);
    hp_table_t t;
    t = '0;
    for (int c = 1; c <= 12; c++) begin
      t[c] = HP_W'(half_period(clk_hz, FREQ_X100[c-1]));
    end
    return t;
  endfunction

  // Default melody: C4/20, E4/20, G4/20, rest/10, C4/40, end.
  function automatic rom_entry_t rom_word(input int unsigned idx);
    case (idx)
      0:       return {NOTE_C4,   8'd20};
      1:       return {NOTE_E4,   8'd20};
      2:       return {NOTE_G4,   8'd20};
      3:       return {NOTE_REST, 8'd10};
      4:       return {NOTE_C4,   8'd40};
      default: return {NOTE_END,  8'd0};
    endcase
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// -----------------------------------------------------------------------------
// note_sequencer_if
// Control/status bundle between a controller and the note sequencer.
//   start, stop        : one-cycle requests from the controller
//   busy, done         : sequencer status (done is a one-cycle pulse)
//   gate               : tone enable for the downstream generator
//   note_half_period   : cycles per half period of the current note
//   note_change        : one-cycle pulse when note_half_period changes
//   note_index         : ROM address of the current entry
// Modports: master = controller side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface note_sequencer_if #(
  parameter int unsigned idx_w = 4
);
  logic                                 start;
  logic                                 stop;
  logic                                 busy;
  logic                                 gate;
  logic [note_sequencer_pkg::HP_W-1:0]  note_half_period;
  logic                                 note_change;
  logic [idx_w-1:0]                     note_index;
  logic                                 done;

  modport master (
    output start, stop,
    input  busy, gate, note_half_period, note_change, note_index, done
  );

  modport slave (
    input  start, stop,
    output busy, gate, note_half_period, note_change, note_index, done
  );
endinterface

// File: rtl/note_sequencer_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running divider producing a one-cycle tick every `period` clocks.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   clear   : synchronous restart; the count is 0 on the following cycle
//   tick    : high on the last cycle of each period
// -----------------------------------------------------------------------------
module tick_divider #(
  parameter int unsigned period = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);
  localparam int unsigned W    = (period > 1) ? $clog2(period) : 1;
  localparam logic [W-1:0] LAST = W'(period - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                   cnt <= '0;
    else if (clear || cnt == LAST)  cnt <= '0;
    else                            cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Plays the melody held in an internal ROM: for each entry drives a half-period
// count and a gate, holds it for `dur` ticks, then drops the gate for
// gap_ticks ticks so repeated notes stay audible.
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : note_sequencer_if.slave (start/stop in; busy, gate,
//             note_half_period, note_change, note_index, done out)
// Optional build macro NOTE_SEQUENCER_LOOP_EN: the melody restarts from entry
// 0 at the end marker or address wrap instead of finishing with done.
// -----------------------------------------------------------------------------
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned clock_frequency = 12000000,
  parameter int unsigned tick_hz         = 100,
  parameter int unsigned gap_ticks       = 2,
  parameter int unsigned rom_depth       = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  note_sequencer_if.slave bus
);
  localparam int unsigned AW          = (rom_depth > 1) ? $clog2(rom_depth) : 1;
  localparam int unsigned TICK_PERIOD = clock_frequency / tick_hz;
  localparam hp_table_t   HP_TABLE    = build_hp_table(clock_frequency);
  localparam logic [7:0]  GAP_LAST    = 8'(gap_ticks - 1);

  // One spare address bit so that address == rom_depth is representable.
  typedef logic [AW:0] addr_t;
  localparam addr_t ADDR_END = addr_t'(rom_depth);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  if (max_half_period(clock_frequency) > 32'd65535) begin : g_hp_range
    $error("note_sequencer: half period exceeds 16 bits for this clock_frequency");
  end

  logic [2:0]      state, state_nxt;
  addr_t           addr, addr_nxt;
  rom_entry_t      rom_q;
  logic [7:0]      tick_cnt;
  logic            tick, tick_clr, enter_play, enter_gap;
  logic            gate_q, change_q;
  logic [HP_W-1:0] hp_q;

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    if (bus.stop) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          state_nxt = S_LOAD;
          addr_nxt  = '0;
        end
        S_LOAD: begin
          if (rom_q.code == NOTE_END || addr == ADDR_END) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
            addr_nxt  = '0;
`else
            state_nxt = S_DONE;
`endif
          end else if (rom_q.dur == 8'd0) begin
            addr_nxt  = addr + addr_t'(1);
          end else begin
            state_nxt = S_PLAY;
          end
        end
        S_PLAY: if (tick && tick_cnt == rom_q.dur - 8'd1) state_nxt = S_GAP;
        S_GAP: if (gap_ticks == 0 || (tick && tick_cnt == GAP_LAST)) begin
          state_nxt = S_LOAD;
          addr_nxt  = addr + addr_t'(1);
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign enter_play = (state_nxt == S_PLAY) && (state != S_PLAY);
  assign enter_gap  = (state_nxt == S_GAP)  && (state != S_GAP);
  // Restarting the divider at each phase entry makes every phase an exact
  // multiple of the tick period.
  assign tick_clr   = enter_play || enter_gap;

  tick_divider #(.period(TICK_PERIOD)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tick_clr),
    .tick    (tick)
  );

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      addr     <= '0;
      rom_q    <= '0;
      tick_cnt <= '0;
      gate_q   <= 1'b0;
      change_q <= 1'b0;
      hp_q     <= '0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      // NOTE: the melody ROM itself is constant logic with nothing to reset;
      // only its output register is reset. Reading with the next address
      // makes the entry valid in the cycle the address takes effect.
      rom_q    <= rom_word(32'(addr_nxt[AW-1:0]));
      change_q <= 1'b0;

      if (tick_clr)  tick_cnt <= '0;
      else if (tick) tick_cnt <= tick_cnt + 8'd1;

      if (enter_play) begin
        hp_q     <= HP_TABLE[rom_q.code];
        change_q <= (HP_TABLE[rom_q.code] != hp_q);
        gate_q   <= is_tone(rom_q.code);
      end else if (state_nxt != S_PLAY) begin
        gate_q   <= 1'b0;
      end
    end
  end

  assign bus.busy             = (state != S_IDLE);
  assign bus.done             = (state == S_DONE);
  assign bus.gate             = gate_q;
  assign bus.note_half_period = hp_q;
  assign bus.note_change      = change_q;
  assign bus.note_index       = addr[AW-1:0];
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream stage for the square-wave tone generators: steps through a fixed melody stored in a small internal ROM.
- For each entry it drives a half-period count (in clock cycles) and a gate to a programmable tone generator, then waits the programmed duration.
- Adds a short articulation gap between notes so that repeated notes are audible.
- Started and stopped by button pulses; reports busy and done.

Parameters:
- clock_frequency, 12000000, input clock rate in Hz.
- tick_hz, 100, duration unit rate (1 tick = 10 ms at default).
- gap_ticks, 2, gate-low ticks appended after every note.
- rom_depth, 16, number of melody entries; address width is clog2(rom_depth).

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  synchronous one-cycle request to play from entry 0
- stop  input  1  synchronous abort
- busy  output  1  high in every state except IDLE
- gate  output  1  tone enable for the downstream generator
- note_half_period  output  16  cycles per half period of the current note
- note_change  output  1  one-cycle pulse when note_half_period takes a new value
- note_index  output  clog2(rom_depth)  address of the current entry
- done  output  1  one-cycle pulse when the melody ends

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0; tick counter 0.
- ROM entry is 12 bits: code[11:8] and dur[7:0].
  - code 0 = rest; codes 1..12 = C4..B4 chromatic; code 15 = end marker; codes 13..14 = rest.
  - ROM read is registered, 1-cycle latency.
- Tick divider: pulses every clock_frequency/tick_hz cycles. It is cleared on entry to PLAY and on entry to GAP, so every phase lasts exactly N*period cycles.
- FSM states:
  - IDLE: start=1 -> LOAD. Address is set to 0.
  - LOAD: ROM data becomes valid. End marker, or address==rom_depth -> DONE. dur==0 -> address+1, stay in LOAD (entry skipped). Otherwise -> PLAY.
  - PLAY: entered one cycle after LOAD.
    - note_half_period = table[code]; note_change pulses on the entry cycle, only if the value differs from the previous one.
    - gate = 1 for codes 1..12, 0 for rests.
    - After dur ticks -> GAP.
  - GAP: gate = 0 for gap_ticks ticks, then address+1 -> LOAD. gap_ticks=0 makes GAP a single cycle.
  - DONE: done=1 for one cycle, gate=0 -> IDLE. note_half_period holds its last value.
- Latency: start sampled at cycle t -> LOAD at t+1 -> gate high at t+2.
- Priority and boundary rules:
  - stop has priority over everything: in any state it forces IDLE on the next cycle, with gate=0 and no done pulse.
  - start while busy is ignored.
  - start and stop in the same cycle: stop wins.
  - Assertion of reset mid-note returns to the reset values immediately.
- Arithmetic:
  - Half period = clock_frequency*100 / (2*freq_mul_100), evaluated at elaboration in 32 bits, then truncated to 16 bits.
  - Values at default clock: C4 = 22933, E4 = 18202, G4 = 15306.
  - Elaboration error if any half period exceeds 65535.

Optional Feature:
- NOTE_SEQUENCER_LOOP_EN:
  - Defined: on end marker or address wrap, LOAD restarts at address 0 with no done pulse; busy stays 1 until stop.
  - Undefined: one-shot play as described above.

Decomposition:
- Package note_sequencer_pkg holds:
  - note code constants (NOTE_REST, NOTE_C4..NOTE_B4, NOTE_END);
  - the frequency*100 table (26163, 27718, 29366, 31113, 32963, 34923, 36999, 39200, 41530, 44000, 46616, 49388);
  - the half-period function;
  - the default melody ROM contents.
- Default melody: C4/20, E4/20, G4/20, rest/10, C4/40, end.
- One sub-module: tick_divider (counter, synchronous clear input, tick pulse output).

Test Plan:
- Default melody playback, with clock_frequency=1000, tick_hz=100 (10 cycles/tick), gap_ticks=2.
  - Stimulus: start pulse at cycle 0.
  - Required response: gate high at cycle 2 for 200 cycles with half_period=(1000*100)/(2*26163)=1, then low 20 cycles.
  - Then E4, G4, and the rest (gate low 100+20 cycles), then C4 for 400 cycles.
  - Finally done pulse, busy=0.
- Stop mid-note: stop during E4 PLAY -> next cycle state IDLE, gate=0, busy=0, no done pulse; a later start replays from index 0.
- Start while busy: pulse start during G4 -> no restart; note_index and timing unchanged.
- Simultaneous start and stop in IDLE -> stays IDLE, busy=0.
- Async reset mid-GAP: reset_n low for 3 cycles -> all outputs 0 immediately; after release, idle until start.
- With NOTE_SEQUENCER_LOOP_EN defined: after the last C4 plus gap, note_index returns to 0 and C4 replays; no done pulse; busy stays 1.
